muldiv_unit: RTL and testbench

- Iterative multiply/divide unit in the execute stage, alongside the ALU.
- Consumes register-file read data (rs, rt) and holds the architectural HI/LO registers.
- Writeback reads HI/LO for mfhi/mflo.
- Implements MULT, MULTU, DIV, DIVU as 32-step shift-add / restoring-divide sequences, plus single-cycle MTHI/MTLO.

---
 rtl/muldiv_unit.sv | 153 +++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// =====================================================================
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO   | rev 1.0
// =====================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
  localparam logic [2:0]       OP_MTHI   = 3'b100;
  localparam logic [2:0]       OP_MTLO   = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic               accept;
  logic [CNT_W-1:0]   count;
  logic               is_div, sign_a, sign_b, div_zero;
  logic [WIDTH-1:0]   a_orig, operand, quot, rem;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic               neg_res;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  // op[0]=0 selects the signed flavour of both MULT and DIV
  always_comb begin
    a_abs     = (~op[0] && a[WIDTH-1]) ? -a : a;
    b_abs     = (~op[0] && b[WIDTH-1]) ? -b : b;
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, operand & {WIDTH{prod[0]}}};
    // W+1-bit trial subtraction: the top bit is the borrow that decides restore
    div_shift = {rem, quot[WIDTH-1]};
    div_diff  = div_shift - {1'b0, operand};
    neg_res   = sign_a ^ sign_b;
    prod_fix  = neg_res ? -prod : prod;
    quot_fix  = neg_res ? -quot : quot;
    rem_fix   = sign_a ? -rem : rem;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !op[2]) begin
          accept   = 1'b1;
          state_nx = CALC;
        end
      end
      CALC: begin
        if (cancel)                  state_nx = IDLE;
        else if (count == LAST_STEP) state_nx = FIX;
      end
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      div_zero <= 1'b0;
      a_orig   <= '0;
      operand  <= '0;
      quot     <= '0;
      rem      <= '0;
      prod     <= '0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != IDLE);
      done  <= (state == FIX) && !cancel;
      case (state)
        IDLE: begin
          if (accept) begin
            is_div   <= op[1];
            sign_a   <= ~op[0] & a[WIDTH-1];
            sign_b   <= ~op[0] & b[WIDTH-1];
            div_zero <= (b == '0);
            a_orig   <= a;
            operand  <= op[1] ? b_abs : a_abs;
            prod     <= {{WIDTH{1'b0}}, b_abs};
            quot     <= a_abs;
            rem      <= '0;
            count    <= '0;
          end else if (start && op == OP_MTHI) begin
            hi <= a;
          end else if (start && op == OP_MTLO) begin
            lo <= a;
          end
        end
        CALC: begin
          count <= count + 1'b1;
          if (is_div) begin
            if (div_diff[WIDTH]) begin
              rem  <= div_shift[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b0};
            end else begin
              rem  <= div_diff[WIDTH-1:0];
              quot <= {quot[WIDTH-2:0], 1'b1};
            end
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!cancel) begin
            if (!is_div) begin
              {hi, lo} <= prod_fix;
            end else if (div_zero) begin
              hi <= a_orig;
              lo <= '1;
            end else begin
              hi <= rem_fix;
              lo <= quot_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// =====================================================================
// tb_muldiv_unit : self-checking bench for muldiv_unit     | rev 1.0
// =====================================================================
`default_nettype none

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic void model(input logic [2:0] mop, input logic [31:0] ma, mb,
                                output logic [31:0] rhi, output logic [31:0] rlo);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] p;
    sa = {{32{ma[31]}}, ma};
    sb = {{32{mb[31]}}, mb};
    p  = '0;
    case (mop)
      3'b000: p = sa * sb;
      3'b001: p = {32'b0, ma} * {32'b0, mb};
      3'b010: begin
        if (mb == 0) p = {ma, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      3'b011: begin
        if (mb == 0) p = {ma, 32'hFFFF_FFFF};
        else p = {ma % mb, ma / mb};
      end
      default: p = {m_hi, m_lo};
    endcase
    rhi = p[63:32];
    rlo = p[31:0];
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or bound expires)
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y,
                        output int bcnt, output bit got_done);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    bcnt = 0; got_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [2:0]  d_op [8] = '{3'd0, 3'd1, 3'd0, 3'd3, 3'd2, 3'd2, 3'd3, 3'd2};
    logic [31:0] d_a  [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd100,
                              32'hFFFFFFF9, 32'h80000000, 32'h1234, 32'hFFFFFFF9};
    logic [31:0] d_b  [8] = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd7,
                              32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] d_hi [8] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'h40000000, 32'd2,
                              32'hFFFFFFFF, 32'h0, 32'h1234, 32'hFFFFFFF9};
    logic [31:0] d_lo [8] = '{32'hFFFFFFF1, 32'h1, 32'h0, 32'd14,
                              32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    int bc;
    bit gd;
    for (int i = 0; i < 8; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], bc, gd);
      checks++; if (!gd) begin errors++; $display("FAIL dir%0d_done got 0 exp 1", i); end
      checks++; if (bc != 33) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d exp 33", i, bc); end
      checks++; if (hi !== d_hi[i]) begin errors++; $display("FAIL dir%0d_hi got %h exp %h", i, hi, d_hi[i]); end
      checks++; if (lo !== d_lo[i]) begin errors++; $display("FAIL dir%0d_lo got %h exp %h", i, lo, d_lo[i]); end
      m_hi = d_hi[i]; m_lo = d_lo[i];
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL dir%0d_done_pulse got %b exp 0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  ro;
    logic [31:0] ra, rb, ehi, elo;
    int bc;
    bit gd;
    for (int i = 0; i < 24; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 7) == 0) rb = 32'h0;
      if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
      model(ro, ra, rb, ehi, elo);
      run_op(ro, ra, rb, bc, gd);
      checks++; if (!gd || bc != 33) begin errors++; $display("FAIL rnd%0d_timing done %b busy_cycles %0d exp 1/33", i, gd, bc); end
      checks++; if (hi !== ehi) begin errors++; $display("FAIL rnd%0d_hi op %0d a %h b %h got %h exp %h", i, ro, ra, rb, hi, ehi); end
      checks++; if (lo !== elo) begin errors++; $display("FAIL rnd%0d_lo op %0d a %h b %h got %h exp %h", i, ro, ra, rb, lo, elo); end
      m_hi = ehi; m_lo = elo;
      @(negedge clk);
    end
  endtask

  task automatic test_mthi_mtlo();
    start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("FAIL mthi_hi got %h exp deadbeef", hi); end
    checks++; if (lo !== m_lo) begin errors++; $display("FAIL mthi_lo got %h exp %h", lo, m_lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mthi_flags got busy %b done %b exp 0 0", busy, done); end
    m_hi = 32'hDEADBEEF;
    start = 1'b1; op = 3'b101; a = 32'h0BADF00D;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo !== 32'h0BADF00D) begin errors++; $display("FAIL mtlo_lo got %h exp 0badf00d", lo); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mtlo_flags got busy %b done %b exp 0 0", busy, done); end
    m_lo = 32'h0BADF00D;
    start = 1'b1; op = 3'b110; a = 32'h55555555;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      errors++; $display("FAIL reserved_op got hi %h lo %h busy %b exp %h %h 0", hi, lo, busy, m_hi, m_lo);
    end
  endtask

  task automatic test_start_ignored();
    int bad_hold = 0;
    bit gd = 1'b0;
    start = 1'b1; op = 3'b011; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'h11111111;
    @(negedge clk);
    start = 1'b0;
    checks++; if (hi !== 32'hDEADBEEF || busy !== 1'b1) begin
      errors++; $display("FAIL ignored_mthi got hi %h busy %b exp deadbeef 1", hi, busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) begin gd = 1'b1; break; end
      if (hi !== 32'hDEADBEEF) bad_hold++;
      @(negedge clk);
    end
    checks++; if (bad_hold != 0 || !gd) begin errors++; $display("FAIL ignored_hold got %0d bad cycles done %b exp 0 1", bad_hold, gd); end
    checks++; if (hi !== 32'd2 || lo !== 32'd14) begin errors++; $display("FAIL ignored_result got hi %h lo %h exp 2 e", hi, lo); end
    m_hi = 32'd2; m_lo = 32'd14;
    @(negedge clk);
  endtask

  task automatic test_cancel();
    int seen = 0;
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cancel_busy got %b exp 0", busy); end
    checks++; if (hi !== m_hi || lo !== m_lo) begin errors++; $display("FAIL cancel_hilo got %h %h exp %h %h", hi, lo, m_hi, m_lo); end
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL cancel_no_done got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_reset_flags got busy %b done %b exp 0 0", busy, done); end
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL async_reset_hilo got %h %h exp 0 0", hi, lo); end
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bc;
    bit gd;
    run_op(3'b000, 32'd6, 32'd7, bc, gd);
    checks++; if (!gd || hi !== 32'd0 || lo !== 32'd42) begin
      errors++; $display("FAIL b2b_first got done %b hi %h lo %h exp 1 0 2a", gd, hi, lo);
    end
    run_op(3'b000, 32'd2, 32'd2, bc, gd);
    checks++; if (!gd || bc != 33) begin errors++; $display("FAIL b2b_timing got done %b busy_cycles %0d exp 1 33", gd, bc); end
    checks++; if (hi !== 32'd0 || lo !== 32'd4) begin errors++; $display("FAIL b2b_second got hi %h lo %h exp 0 4", hi, lo); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_mthi_mtlo();
    test_start_ignored();
    test_cancel();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
